// File: rtl/seg7_to_bcd_capture_if.sv
// Bundle of the sampled display bus and the decoded per-digit results.
// The master drives the seven-segment pins; the decoder sits on the slave side.
interface seg7_to_bcd_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic [NUM_DIGITS-1:0]   err_flag;
  logic                    err_pulse;
  logic                    frame_valid;

  // No handshake: the pins are level-sampled every cycle; err_pulse and
  // frame_valid are single-cycle strobes, the remaining outputs are levels.
  modport master (
    output seg_in, dig_sel,
    input  bcd_out, digit_valid, err_flag, err_pulse, frame_valid
  );

  modport slave (
    input  seg_in, dig_sel,
    output bcd_out, digit_valid, err_flag, err_pulse, frame_valid
  );
endinterface

// File: rtl/seg7_to_bcd_capture.sv
// Samples a multiplexed seven-segment bus, waits for a stable pattern on a
// single selected digit, decodes it to BCD and tracks per-digit and frame status.
module seg7_to_bcd_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  seg7_to_bcd_capture_if.slave bus
);
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [6:0]              samp_seg_q, samp_seg_d;
  logic [NUM_DIGITS-1:0]   samp_sel_q, samp_sel_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   dv_q, dv_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    err_pulse_q, err_pulse_d;
  logic                    frame_q, frame_d;

  logic                    same;
  logic                    one_hot;
  logic                    capture;
  logic [4:0]              dec;
  logic [NUM_DIGITS-1:0]   seen_tmp;

  // Returns {valid, nibble}; an all-dark digit is a legal blank (F).
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h7E:   decode = 5'h10;
      7'h30:   decode = 5'h11;
      7'h6D:   decode = 5'h12;
      7'h79:   decode = 5'h13;
      7'h33:   decode = 5'h14;
      7'h5B:   decode = 5'h15;
      7'h5F:   decode = 5'h16;
      7'h70:   decode = 5'h17;
      7'h7F:   decode = 5'h18;
      7'h7B:   decode = 5'h19;
      7'h00:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    samp_seg_d  = bus.seg_in;
    samp_sel_d  = bus.dig_sel;
    // A zero count marks the first sample after reset, which opens a window.
    same        = (cnt_q != 8'd0) && (bus.seg_in == samp_seg_q) &&
                  (bus.dig_sel == samp_sel_q);
    one_hot     = (samp_sel_q != '0) && ((samp_sel_q & (samp_sel_q - 1'b1)) == '0);
    capture     = same && (cnt_q >= STABLE - 8'd1) && !done_q && one_hot;
    dec         = decode(samp_seg_q);
    cnt_d       = same ? ((cnt_q < STABLE) ? cnt_q + 8'd1 : cnt_q) : 8'd1;
    done_d      = same ? done_q : 1'b0;
    seen_d      = seen_q;
    seen_tmp    = seen_q | samp_sel_q;
    bcd_d       = bcd_q;
    dv_d        = dv_q;
    err_d       = err_q;
    err_pulse_d = 1'b0;
    frame_d     = 1'b0;

    if (capture) begin
      done_d = 1'b1;
      if (dec[4]) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (samp_sel_q[i]) bcd_d[4*i +: 4] = dec[3:0];
        end
        dv_d  = dv_q | samp_sel_q;
        err_d = err_q & ~samp_sel_q;
        // The completing capture is not carried into the next frame.
        if (&seen_tmp) begin
          frame_d = 1'b1;
          seen_d  = '0;
        end else begin
          seen_d  = seen_tmp;
        end
      end else begin
        err_d       = err_q | samp_sel_q;
        err_pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_seg_q  <= '0;
      samp_sel_q  <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      seen_q      <= '0;
      bcd_q       <= '0;
      dv_q        <= '0;
      err_q       <= '0;
      err_pulse_q <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      samp_seg_q  <= samp_seg_d;
      samp_sel_q  <= samp_sel_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      seen_q      <= seen_d;
      bcd_q       <= bcd_d;
      dv_q        <= dv_d;
      err_q       <= err_d;
      err_pulse_q <= err_pulse_d;
      frame_q     <= frame_d;
    end
  end

  assign bus.bcd_out     = bcd_q;
  assign bus.digit_valid = dv_q;
  assign bus.err_flag    = err_q;
  assign bus.err_pulse   = err_pulse_q;
  assign bus.frame_valid = frame_q;
endmodule

// File: tb/tb_seg7_to_bcd_capture.sv
// Directed and randomized bench for seg7_to_bcd_capture with a run-length
// reference model of the capture rules.
module tb_seg7_to_bcd_capture;
  localparam int ND = 4;
  localparam int S  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   fv_seen = 0;
  int   ep_seen = 0;

  seg7_to_bcd_capture_if #(.NUM_DIGITS(ND)) bus ();

  seg7_to_bcd_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [6:0]  pat_tbl [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  logic [15:0] exp_bcd;
  logic [3:0]  exp_dv, exp_err, exp_seen;
  logic        exp_ep, exp_fv;
  int          run;
  logic [6:0]  last_seg;
  logic [3:0]  last_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lookup(input logic [6:0] seg);
    if (seg == 7'h00) return 15;
    for (int k = 0; k < 10; k++) if (pat_tbl[k] == seg) return k;
    return -1;
  endfunction

  task automatic model_reset();
    exp_bcd = '0; exp_dv = '0; exp_err = '0; exp_seen = '0;
    exp_ep = 1'b0; exp_fv = 1'b0; run = 0;
    last_seg = '0; last_sel = '0;
  endtask

  // The S-th identical consecutive sample on a single selected digit captures.
  task automatic model_step(input logic [6:0] s, input logic [3:0] d);
    int v;
    if (run > 0 && s == last_seg && d == last_sel) run++;
    else run = 1;
    last_seg = s; last_sel = d;
    exp_ep = 1'b0; exp_fv = 1'b0;
    if (run == S && $countones(d) == 1) begin
      v = lookup(s);
      for (int i = 0; i < ND; i++) begin
        if (d[i]) begin
          if (v >= 0) begin
            exp_bcd[4*i +: 4] = 4'(v);
            exp_dv[i]   = 1'b1;
            exp_err[i]  = 1'b0;
            exp_seen[i] = 1'b1;
          end else begin
            exp_err[i] = 1'b1;
            exp_ep     = 1'b1;
          end
        end
      end
      if (exp_seen == 4'hF) begin
        exp_fv   = 1'b1;
        exp_seen = '0;
      end
    end
  endtask

  task automatic cycle(input logic [6:0] s, input logic [3:0] d);
    bus.seg_in  = s;
    bus.dig_sel = d;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else model_step(s, d);
    check("bcd_out",     32'(bus.bcd_out),     32'(exp_bcd));
    check("digit_valid", 32'(bus.digit_valid), 32'(exp_dv));
    check("err_flag",    32'(bus.err_flag),    32'(exp_err));
    check("err_pulse",   32'(bus.err_pulse),   32'(exp_ep));
    check("frame_valid", 32'(bus.frame_valid), 32'(exp_fv));
    fv_seen += int'(bus.frame_valid);
    ep_seen += int'(bus.err_pulse);
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
    for (int k = 0; k < n; k++) cycle(s, d);
  endtask

  task automatic reset_cycles(input int n);
    rst = 1'b1;
    hold(bus.seg_in, bus.dig_sel, n);
    rst = 1'b0;
  endtask

  initial begin
    bus.seg_in  = '0;
    bus.dig_sel = '0;
    model_reset();
    hold(7'h00, 4'h0, 2);
    rst = 1'b0;
    check("reset_bcd", 32'(bus.bcd_out), 32'h0);

    // Single digit 2 on position 0
    fv_seen = 0; ep_seen = 0;
    hold(7'h6D, 4'b0001, 10);
    check("d0_nibble", 32'(bus.bcd_out[3:0]), 32'h2);
    check("d0_valid",  32'(bus.digit_valid), 32'h1);
    check("d0_pulses", 32'(fv_seen + ep_seen), 32'h0);

    // Full scan 3,7,0,9
    fv_seen = 0;
    hold(7'h79, 4'b0001, 6);
    hold(7'h70, 4'b0010, 6);
    hold(7'h7E, 4'b0100, 6);
    hold(7'h7B, 4'b1000, 6);
    check("scan_bcd",    32'(bus.bcd_out), 32'h9073);
    check("scan_valid",  32'(bus.digit_valid), 32'hF);
    check("scan_frames", 32'(fv_seen), 32'h1);

    // Invalid pattern then recovery on position 2
    ep_seen = 0;
    hold(7'h01, 4'b0100, 6);
    check("inv_pulses", 32'(ep_seen), 32'h1);
    check("inv_flag",   32'(bus.err_flag), 32'h4);
    check("inv_nibble", 32'(bus.bcd_out[11:8]), 32'h0);
    hold(7'h5F, 4'b0100, 6);
    check("rec_flag",   32'(bus.err_flag), 32'h0);
    check("rec_nibble", 32'(bus.bcd_out[11:8]), 32'h6);

    // Glitch filtering: toggling pattern and non-one-hot selects
    for (int k = 0; k < 8; k++) hold((k % 2 == 0) ? 7'h30 : 7'h33, 4'b0010, 2);
    check("glitch_nibble", 32'(bus.bcd_out[7:4]), 32'h7);
    ep_seen = 0;
    hold(7'h30, 4'b0011, 6);
    hold(7'h30, 4'b0000, 6);
    check("ghost_nibble", 32'(bus.bcd_out[7:0]), 32'h73);
    check("ghost_err",    32'(ep_seen), 32'h0);

    // Reset in the middle of position 3's window
    hold(7'h30, 4'b0001, 6);
    hold(7'h6D, 4'b0010, 6);
    hold(7'h79, 4'b0100, 6);
    hold(7'h33, 4'b1000, 2);
    reset_cycles(1);
    check("mid_rst_bcd",   32'(bus.bcd_out), 32'h0);
    check("mid_rst_valid", 32'(bus.digit_valid), 32'h0);
    fv_seen = 0;
    hold(7'h33, 4'b0001, 6);
    hold(7'h5B, 4'b0010, 6);
    hold(7'h7F, 4'b0100, 5);
    check("rst_no_frame_yet", 32'(fv_seen), 32'h0);
    hold(7'h7E, 4'b1000, 6);
    check("rst_frame", 32'(fv_seen), 32'h1);

    // Blank on position 3
    fv_seen = 0;
    hold(7'h30, 4'b0001, 6);
    hold(7'h30, 4'b0010, 6);
    hold(7'h30, 4'b0100, 6);
    hold(7'h00, 4'b1000, 6);
    check("blank_nibble", 32'(bus.bcd_out[15:12]), 32'hF);
    check("blank_valid",  32'(bus.digit_valid), 32'hF);
    check("blank_frame",  32'(fv_seen), 32'h1);

    // Randomized holds against the model
    for (int h = 0; h < 400; h++) begin
      logic [6:0] s;
      logic [3:0] d;
      int r;
      r = $urandom_range(0, 11);
      if (r < 10) s = pat_tbl[r];
      else if (r == 10) s = 7'h00;
      else s = 7'($urandom_range(0, 127));
      r = $urandom_range(0, 4);
      d = (r < 4) ? 4'(1 << r) : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) reset_cycles(1);
      hold(s, d, $urandom_range(1, 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
